// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one byte-wide SDRAM controller between the PPU
// (read-only), the CPU (read/write) and the ROM loader (write-only).
// One access is granted per clkref period ("slot"). A slot without a grant
// lets the controller auto-refresh. After REFRESH_MAX back-to-back granted
// slots, an idle slot is forced.
module sdram_arbiter #(
  parameter int REFRESH_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clkref,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  input  logic        ppu_req,
  input  logic [24:0] ppu_addr,
  output logic        ppu_ack,
  output logic [7:0]  ppu_dout,
  input  logic        ldr_req,
  input  logic [24:0] ldr_addr,
  input  logic [7:0]  ldr_din,
  output logic        ldr_ack,
  output logic [24:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_din,
  output logic        mem_oeA,
  output logic        mem_oeB,
  input  logic [7:0]  mem_doutA,
  input  logic [7:0]  mem_doutB,
  output logic [1:0]  slot_owner
);

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_PPU  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_LDR  = 2'd3;

  localparam logic [7:0] BUSY_MAX = 8'(REFRESH_MAX);

  logic       clkref_q;
  logic       boundary;
  logic [7:0] busy_cnt;
  logic       ppu_elig;
  logic       cpu_elig;
  logic       ldr_elig;
  logic [1:0] next_owner;

  // A slot starts on the first SDRAM clock that sees clkref high after low.
  assign boundary = clkref & ~clkref_q;

  // Delayed copy of clkref for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clkref_q <= 1'b0;
    end else begin
      clkref_q <= clkref;
    end
  end

  // Choose the owner of the next slot: the owner of the closing slot may not
  // win again, and a full busy counter forces a refresh slot.
  always_comb begin
    ppu_elig   = ppu_req && (slot_owner != OWN_PPU);
    cpu_elig   = cpu_req && (slot_owner != OWN_CPU);
    ldr_elig   = ldr_req && (slot_owner != OWN_LDR);
    next_owner = OWN_IDLE;
    if (busy_cnt != BUSY_MAX) begin
      if (ppu_elig) begin
        next_owner = OWN_PPU;
      end else if (cpu_elig) begin
        next_owner = OWN_CPU;
      end else if (ldr_elig) begin
        next_owner = OWN_LDR;
      end
    end
  end

  // Count consecutive granted slots; any idle slot restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_cnt <= 8'd0;
    end else if (boundary) begin
      if (next_owner == OWN_IDLE) begin
        busy_cnt <= 8'd0;
      end else if (busy_cnt != BUSY_MAX) begin
        busy_cnt <= busy_cnt + 8'd1;
      end
    end
  end

  // Record who owns the slot that just opened.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_owner <= OWN_IDLE;
    end else if (boundary) begin
      slot_owner <= next_owner;
    end
  end

  // One-clock completion pulse to the owner of the slot being closed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_ack <= 1'b0;
      ppu_ack <= 1'b0;
      ldr_ack <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ppu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      if (boundary) begin
        case (slot_owner)
          OWN_PPU: ppu_ack <= 1'b1;
          OWN_CPU: cpu_ack <= 1'b1;
          OWN_LDR: ldr_ack <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Capture read data from the controller as the read slot closes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_dout <= 8'd0;
      ppu_dout <= 8'd0;
    end else if (boundary) begin
      if (slot_owner == OWN_PPU) begin
        ppu_dout <= mem_doutB;
      end
      if ((slot_owner == OWN_CPU) && mem_oeA) begin
        cpu_dout <= mem_doutA;
      end
    end
  end

  // Latch the winner's payload onto the controller bus for the whole slot;
  // an idle slot drops all strobes but keeps address and data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_addr <= 25'd0;
      mem_din  <= 8'd0;
      mem_we   <= 1'b0;
      mem_oeA  <= 1'b0;
      mem_oeB  <= 1'b0;
    end else if (boundary) begin
      mem_we  <= 1'b0;
      mem_oeA <= 1'b0;
      mem_oeB <= 1'b0;
      case (next_owner)
        OWN_PPU: begin
          mem_addr <= ppu_addr;
          mem_oeB  <= 1'b1;
        end
        OWN_CPU: begin
          mem_addr <= cpu_addr;
          if (cpu_we) begin
            mem_din <= cpu_din;
            mem_we  <= 1'b1;
          end else begin
            mem_oeA <= 1'b1;
          end
        end
        OWN_LDR: begin
          mem_addr <= ldr_addr;
          mem_din  <= ldr_din;
          mem_we   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
